bit_block_counter_p: RTL and testbench

Parametrised successor of the 32-bit block counter. Counts blocks (runs of at least `MIN_LEN` consecutive 1s) in each incoming word and reports the per-word count. It also keeps a frame-level count in which a block spanning a word boundary is counted once. It sits on the same streaming data path as the fixed-width counter and feeds the statistics logic, with a fixed 2-cycle latency.

---
 rtl/bbc_pkg.sv | 22 ++
 rtl/bbc_word_scan.sv | 41 ++++
 rtl/bit_block_counter_p.sv | 179 +++++++++++++++++
 tb/tb_bit_block_counter_p.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_pkg.sv
// Shared types and elaboration helpers for the parametrised block counter.
// Holds the frame FSM state encoding and the minimum per-word count width.
package bbc_pkg;

    typedef enum logic [0:0] {
        BBC_IDLE     = 1'b0,
        BBC_IN_FRAME = 1'b1
    } bbc_state_e;

    // Smallest width able to hold DATA_W/(MIN_LEN+1)+1, the worst-case word count.
    function automatic int bbc_min_cnt_w(input int dataW, input int minLen);
        int maxCnt;
        int w;
        maxCnt = dataW / (minLen + 1) + 1;
        w = 1;
        while ((1 << w) <= maxCnt) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bbc_word_scan.sv
// Combinational LSB-first scan of one word: counts runs reaching MIN_LEN ones,
// starting from a carried-in run length and returning the run length at the MSB.
module bbc_word_scan
    import bbc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MIN_LEN = 1,
    parameter int CNT_W   = 6,
    parameter int RUN_W   = $clog2(MIN_LEN + 1)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [RUN_W-1:0]  i_carry,
    output logic [CNT_W-1:0]  o_count,
    output logic [RUN_W-1:0]  o_carry
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_LEN);

    logic [RUN_W-1:0] w_run;
    logic [CNT_W-1:0] w_cnt;

    // The run length saturates at MIN_LEN, so a run is counted only on the bit that reaches it.
    always_comb begin
        w_run = i_carry;
        w_cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!i_word[i]) begin
                w_run = '0;
            end else if (w_run != RUN_MAX) begin
                w_run = w_run + RUN_W'(1);
                if (w_run == RUN_MAX) begin
                    w_cnt = w_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_count = w_cnt;
    assign o_carry = w_run;

endmodule

// File: rtl/bit_block_counter_p.sv
// Streaming block counter: per-word block count plus a frame-level count in which
// runs crossing word boundaries count once. Two register stages, one word per cycle.
module bit_block_counter_p
    import bbc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MIN_LEN = 1,
    parameter int CNT_W   = 6,
    parameter int FCNT_W  = 16,
    parameter int FF_DLY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_enb,
    input  logic              sop,
    input  logic              eop,
    output logic [CNT_W-1:0]  block_cnt,
    output logic              valid,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              frame_valid,
    output logic              frame_ovf,
    output logic              frame_err
);

    localparam int RUN_W = $clog2(MIN_LEN + 1);
    localparam int SUM_W = ((FCNT_W > CNT_W) ? FCNT_W : CNT_W) + 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    if (DATA_W < 2) begin : g_chk_data_w
        $error("bit_block_counter_p: DATA_W=%0d must be at least 2", DATA_W);
    end
    if (MIN_LEN < 1 || MIN_LEN > DATA_W) begin : g_chk_min_len
        $error("bit_block_counter_p: MIN_LEN=%0d out of range 1..%0d", MIN_LEN, DATA_W);
    end
    if (CNT_W < bbc_min_cnt_w(DATA_W, MIN_LEN)) begin : g_chk_cnt_w
        $error("bit_block_counter_p: CNT_W=%0d too narrow, need %0d", CNT_W,
               bbc_min_cnt_w(DATA_W, MIN_LEN));
    end
    if (FF_DLY < 0) begin : g_chk_ff_dly
        $error("bit_block_counter_p: FF_DLY=%0d must be non-negative", FF_DLY);
    end

    logic [DATA_W-1:0] r_data;
    logic              r_enb;
    logic              r_sop;
    logic              r_eop;

    bbc_state_e        r_state;
    bbc_state_e        w_stateNext;
    logic [FCNT_W-1:0] r_acc;
    logic [FCNT_W-1:0] w_accNext;
    logic              r_ovf;
    logic              w_ovfNext;
    logic [RUN_W-1:0]  r_runCarry;
    logic [RUN_W-1:0]  w_carryNext;

    logic [CNT_W-1:0]  w_wordCnt;
    logic [RUN_W-1:0]  w_wordCarry;
    logic [CNT_W-1:0]  w_frameCnt;
    logic [RUN_W-1:0]  w_frameCarry;

    logic [FCNT_W-1:0] w_base;
    logic [CNT_W-1:0]  w_inc;
    logic [SUM_W-1:0]  w_sum;
    logic              w_publish;
    logic              w_err;

    // sop/eop are folded with data_enb here so later stages only need r_enb for qualification.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_data <= '0;
            r_enb  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
        end else begin
            r_enb <= data_enb;
            r_sop <= data_enb & sop;
            r_eop <= data_enb & eop;
            if (data_enb) begin
                r_data <= data;
            end
        end
    end

    bbc_word_scan #(
        .DATA_W  (DATA_W),
        .MIN_LEN (MIN_LEN),
        .CNT_W   (CNT_W),
        .RUN_W   (RUN_W)
    ) u_scan_word (
        .i_word  (r_data),
        .i_carry ({RUN_W{1'b0}}),
        .o_count (w_wordCnt),
        .o_carry (w_wordCarry)
    );

    bbc_word_scan #(
        .DATA_W  (DATA_W),
        .MIN_LEN (MIN_LEN),
        .CNT_W   (CNT_W),
        .RUN_W   (RUN_W)
    ) u_scan_frame (
        .i_word  (r_data),
        .i_carry (r_runCarry),
        .o_count (w_frameCnt),
        .o_carry (w_frameCarry)
    );

    // A sop word starts from a zero carry, which is exactly what the word-local scan computed.
    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_ovfNext   = r_ovf;
        w_carryNext = r_runCarry;
        w_base      = r_acc;
        w_inc       = w_frameCnt;
        w_sum       = '0;
        w_publish   = 1'b0;
        w_err       = 1'b0;
        if (r_enb && (r_sop || r_state == BBC_IN_FRAME)) begin
            w_err       = r_sop && (r_state == BBC_IN_FRAME);
            w_base      = r_sop ? '0 : r_acc;
            w_inc       = r_sop ? w_wordCnt : w_frameCnt;
            w_carryNext = r_sop ? w_wordCarry : w_frameCarry;
            w_sum       = SUM_W'(w_base) + SUM_W'(w_inc);
            if (w_sum > SUM_W'(FCNT_MAX)) begin
                w_accNext = FCNT_MAX;
                w_ovfNext = 1'b1;
            end else begin
                w_accNext = w_sum[FCNT_W-1:0];
                w_ovfNext = r_sop ? 1'b0 : r_ovf;
            end
            if (r_eop) begin
                w_publish   = 1'b1;
                w_stateNext = BBC_IDLE;
            end else begin
                w_stateNext = BBC_IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= BBC_IDLE;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_runCarry <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_acc      <= w_accNext;
            r_ovf      <= w_ovfNext;
            r_runCarry <= w_carryNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            block_cnt   <= '0;
            valid       <= 1'b0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            frame_ovf   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            valid       <= r_enb;
            frame_valid <= w_publish;
            frame_err   <= w_err;
            if (r_enb) begin
                block_cnt <= w_wordCnt;
            end
            if (w_publish) begin
                frame_cnt <= w_accNext;
                frame_ovf <= w_ovfNext;
            end
        end
    end

endmodule

// File: tb/tb_bit_block_counter_p.sv
// Bench for bit_block_counter_p: four instances with different MIN_LEN/FCNT_W share one
// input stream; directed scenarios plus a random stream checked against a run-counting model.
module tb_bit_block_counter_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_enb;
    logic        sop;
    logic        eop;
    logic [31:0] data;

    logic        v  [4];
    logic [5:0]  bc [4];
    logic [15:0] fc [4];
    logic        fv [4];
    logic        fo [4];
    logic        fe [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gInst
            localparam int ML = (g == 1) ? 2 : ((g == 2) ? 4 : 1);
            localparam int FW = (g == 3) ? 4 : 16;
            logic [FW-1:0] fcLocal;
            bit_block_counter_p #(
                .DATA_W (32),
                .MIN_LEN(ML),
                .CNT_W  (6),
                .FCNT_W (FW),
                .FF_DLY (1)
            ) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .data       (data),
                .data_enb   (data_enb),
                .sop        (sop),
                .eop        (eop),
                .block_cnt  (bc[g]),
                .valid      (v[g]),
                .frame_cnt  (fcLocal),
                .frame_valid(fv[g]),
                .frame_ovf  (fo[g]),
                .frame_err  (fe[g])
            );
            assign fc[g] = 16'(fcLocal);
        end
    endgenerate

    function automatic int mlOf(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 4 : 1);
    endfunction

    function automatic int fwOf(input int i);
        return (i == 3) ? 4 : 16;
    endfunction

    // Number of maximal runs of ones of length >= ml in the concatenated words, bit 0 first.
    function automatic int countRuns(input logic [31:0] words [$], input int ml);
        int runs = 0;
        int len = 0;
        foreach (words[w]) begin
            for (int b = 0; b < 32; b++) begin
                if (words[w][b]) begin
                    len++;
                end else begin
                    if (len >= ml) runs++;
                    len = 0;
                end
            end
        end
        if (len >= ml) runs++;
        return runs;
    endfunction

    task automatic drive(input logic [31:0] d, input logic e, input logic s, input logic p);
        data     = d;
        data_enb = e;
        sop      = s;
        eop      = p;
        @(negedge clk);
    endtask

    // Disabled cycle with garbage on every qualified input.
    task automatic idleCycle();
        drive($urandom, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic applyReset();
        rst_n    = 1'b1;
        data_enb = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        data     = '1;
        data_enb = 1'b1;
        sop      = 1'b1;
        eop      = 1'b1;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        data_enb = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (v[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid inst%0d: got %0d expected 0", i, v[i]); end
            checks++; if (bc[i] !== 6'd0) begin errors++; $display("[TB] FAIL reset_block_cnt inst%0d: got %0d expected 0", i, bc[i]); end
            checks++; if (fc[i] !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt inst%0d: got %0d expected 0", i, fc[i]); end
            checks++; if ({fv[i], fo[i], fe[i]} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags inst%0d: got %b expected 000", i, {fv[i], fo[i], fe[i]}); end
        end
    endtask

    task automatic test_single_word();
        drive(32'hF0F0_0F0F, 1'b1, 1'b1, 1'b1);
        checks++; if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %0d expected 0", v[0]); end
        idleCycle();
        checks++; if (v[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0d expected 1", v[0]); end
        checks++; if (bc[0] !== 6'd4) begin errors++; $display("[TB] FAIL single_block_cnt: got %0d expected 4", bc[0]); end
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_frame_valid: got %0d expected 1", fv[0]); end
        checks++; if (fc[0] !== 16'd4) begin errors++; $display("[TB] FAIL single_frame_cnt: got %0d expected 4", fc[0]); end
        checks++; if (fo[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_frame_ovf: got %0d expected 0", fo[0]); end
        checks++; if (bc[2] !== 6'd4) begin errors++; $display("[TB] FAIL single_block_cnt_ml4: got %0d expected 4", bc[2]); end
        checks++; if (fc[2] !== 16'd4) begin errors++; $display("[TB] FAIL single_frame_cnt_ml4: got %0d expected 4", fc[2]); end
        idleCycle();
        checks++; if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_pulse: got %0d expected 0", v[0]); end
        checks++; if (fv[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_fv_pulse: got %0d expected 0", fv[0]); end
        checks++; if (fc[0] !== 16'd4) begin errors++; $display("[TB] FAIL single_frame_hold: got %0d expected 4", fc[0]); end
    endtask

    task automatic test_min_len2();
        drive(32'h5555_5557, 1'b1, 1'b0, 1'b1);
        idleCycle();
        checks++; if (v[1] !== 1'b1) begin errors++; $display("[TB] FAIL ml2_valid: got %0d expected 1", v[1]); end
        checks++; if (bc[1] !== 6'd1) begin errors++; $display("[TB] FAIL ml2_block_cnt: got %0d expected 1", bc[1]); end
        checks++; if (bc[0] !== 6'd15) begin errors++; $display("[TB] FAIL ml1_block_cnt: got %0d expected 15", bc[0]); end
        checks++; if (fv[1] !== 1'b0) begin errors++; $display("[TB] FAIL idle_eop_frame_valid: got %0d expected 0", fv[1]); end
        checks++; if (fc[0] !== 16'd4) begin errors++; $display("[TB] FAIL idle_eop_frame_hold: got %0d expected 4", fc[0]); end
    endtask

    task automatic test_cross_boundary();
        drive(32'hC000_0000, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_0003, 1'b1, 1'b0, 1'b1);
        checks++; if (bc[2] !== 6'd0) begin errors++; $display("[TB] FAIL cross_w0_block_cnt: got %0d expected 0", bc[2]); end
        checks++; if (fv[2] !== 1'b0) begin errors++; $display("[TB] FAIL cross_w0_frame_valid: got %0d expected 0", fv[2]); end
        checks++; if (bc[0] !== 6'd1) begin errors++; $display("[TB] FAIL cross_w0_block_cnt_ml1: got %0d expected 1", bc[0]); end
        idleCycle();
        checks++; if (bc[2] !== 6'd0) begin errors++; $display("[TB] FAIL cross_w1_block_cnt: got %0d expected 0", bc[2]); end
        checks++; if (fv[2] !== 1'b1) begin errors++; $display("[TB] FAIL cross_frame_valid: got %0d expected 1", fv[2]); end
        checks++; if (fc[2] !== 16'd1) begin errors++; $display("[TB] FAIL cross_frame_cnt_ml4: got %0d expected 1", fc[2]); end
        checks++; if (fc[0] !== 16'd1) begin errors++; $display("[TB] FAIL cross_frame_cnt_ml1: got %0d expected 1", fc[0]); end
    endtask

    task automatic test_saturation();
        drive(32'h5555_5555, 1'b1, 1'b1, 1'b0);
        drive(32'h5555_5555, 1'b1, 1'b0, 1'b1);
        idleCycle();
        checks++; if (fv[3] !== 1'b1) begin errors++; $display("[TB] FAIL sat_frame_valid: got %0d expected 1", fv[3]); end
        checks++; if (fc[3] !== 16'd15) begin errors++; $display("[TB] FAIL sat_frame_cnt: got %0d expected 15", fc[3]); end
        checks++; if (fo[3] !== 1'b1) begin errors++; $display("[TB] FAIL sat_frame_ovf: got %0d expected 1", fo[3]); end
        checks++; if (fc[0] !== 16'd32) begin errors++; $display("[TB] FAIL wide_frame_cnt: got %0d expected 32", fc[0]); end
        checks++; if (fo[0] !== 1'b0) begin errors++; $display("[TB] FAIL wide_frame_ovf: got %0d expected 0", fo[0]); end
    endtask

    task automatic test_sop_mid_frame();
        drive(32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        checks++; if (fe[0] !== 1'b0) begin errors++; $display("[TB] FAIL midsop_first_err: got %0d expected 0", fe[0]); end
        drive(32'h0000_0000, 1'b1, 1'b0, 1'b1);
        checks++; if (fe[0] !== 1'b1) begin errors++; $display("[TB] FAIL midsop_err: got %0d expected 1", fe[0]); end
        checks++; if (fv[0] !== 1'b0) begin errors++; $display("[TB] FAIL midsop_early_fv: got %0d expected 0", fv[0]); end
        idleCycle();
        checks++; if (fe[0] !== 1'b0) begin errors++; $display("[TB] FAIL midsop_err_pulse: got %0d expected 0", fe[0]); end
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("[TB] FAIL midsop_frame_valid: got %0d expected 1", fv[0]); end
        checks++; if (fc[0] !== 16'd1) begin errors++; $display("[TB] FAIL midsop_frame_cnt: got %0d expected 1", fc[0]); end
        checks++; if (fc[3] !== 16'd1) begin errors++; $display("[TB] FAIL midsop_frame_cnt_fw4: got %0d expected 1", fc[3]); end
        checks++; if (fo[3] !== 1'b0) begin errors++; $display("[TB] FAIL midsop_ovf_cleared: got %0d expected 0", fo[3]); end
    endtask

    task automatic test_back_to_back();
        drive(32'h0000_0003, 1'b1, 1'b1, 1'b1);
        drive(32'h0000_0005, 1'b1, 1'b1, 1'b1);
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_fv: got %0d expected 1", fv[0]); end
        checks++; if (fc[0] !== 16'd1) begin errors++; $display("[TB] FAIL b2b_first_cnt: got %0d expected 1", fc[0]); end
        checks++; if (fc[1] !== 16'd1) begin errors++; $display("[TB] FAIL b2b_first_cnt_ml2: got %0d expected 1", fc[1]); end
        idleCycle();
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_fv: got %0d expected 1", fv[0]); end
        checks++; if (fc[0] !== 16'd2) begin errors++; $display("[TB] FAIL b2b_second_cnt: got %0d expected 2", fc[0]); end
        checks++; if (fc[1] !== 16'd0) begin errors++; $display("[TB] FAIL b2b_second_cnt_ml2: got %0d expected 0", fc[1]); end
        checks++; if (fe[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err: got %0d expected 0", fe[0]); end
    endtask

    task automatic test_idle_hold();
        drive(32'h8000_0000, 1'b1, 1'b1, 1'b0);
        idleCycle();
        checks++; if (v[0] !== 1'b1 || bc[0] !== 6'd1) begin errors++; $display("[TB] FAIL hold_w0: got valid %0d cnt %0d expected 1 1", v[0], bc[0]); end
        idleCycle();
        checks++; if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL hold_gap_valid: got %0d expected 0", v[0]); end
        idleCycle();
        checks++; if (fe[0] !== 1'b0 || fv[0] !== 1'b0) begin errors++; $display("[TB] FAIL hold_gap_pulses: got err %0d fv %0d expected 0 0", fe[0], fv[0]); end
        drive(32'h0000_0001, 1'b1, 1'b0, 1'b1);
        idleCycle();
        checks++; if (v[0] !== 1'b1) begin errors++; $display("[TB] FAIL hold_w1_valid: got %0d expected 1", v[0]); end
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("[TB] FAIL hold_frame_valid: got %0d expected 1", fv[0]); end
        checks++; if (fc[0] !== 16'd1) begin errors++; $display("[TB] FAIL hold_frame_cnt_ml1: got %0d expected 1", fc[0]); end
        checks++; if (fc[1] !== 16'd1) begin errors++; $display("[TB] FAIL hold_frame_cnt_ml2: got %0d expected 1", fc[1]); end
        checks++; if (fc[2] !== 16'd0) begin errors++; $display("[TB] FAIL hold_frame_cnt_ml4: got %0d expected 0", fc[2]); end
    endtask

    task automatic test_reset_mid_pipeline();
        drive(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        data     = 32'h0000_FFFF;
        data_enb = 1'b1;
        sop      = 1'b0;
        eop      = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (v[i] !== 1'b0 || fc[i] !== 16'd0 || bc[i] !== 6'd0) begin errors++; $display("[TB] FAIL midrst_outputs inst%0d: got valid %0d cnt %0d fcnt %0d expected 0 0 0", i, v[i], bc[i], fc[i]); end
            checks++; if ({fv[i], fo[i], fe[i]} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_flags inst%0d: got %b expected 000", i, {fv[i], fo[i], fe[i]}); end
        end
        rst_n    = 1'b0;
        data_enb = 1'b0;
        @(negedge clk);
        checks++; if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drained_valid: got %0d expected 0", v[0]); end
        drive(32'h0000_FFFF, 1'b1, 1'b0, 1'b1);
        idleCycle();
        checks++; if (v[0] !== 1'b1 || bc[0] !== 6'd1) begin errors++; $display("[TB] FAIL postrst_word: got valid %0d cnt %0d expected 1 1", v[0], bc[0]); end
        checks++; if (fv[0] !== 1'b0) begin errors++; $display("[TB] FAIL postrst_no_frame: got %0d expected 0", fv[0]); end
    endtask

    task automatic test_random();
        logic [31:0] frameWords [$];
        logic [31:0] oneWord [$];
        logic        inFrame = 1'b0;
        logic [15:0] pubFc [4];
        logic        pubFo [4];
        logic        pV = 1'b0, pFv = 1'b0, pFe = 1'b0;
        logic [5:0]  pBc [4];
        logic [15:0] pFc [4];
        logic        pFo [4];
        logic        nV, nFv, nFe;
        logic [5:0]  nBc [4];
        logic [31:0] d;
        logic        e, s, p;
        int          tot, mx;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            pubFc[i] = '0; pubFo[i] = 1'b0; pBc[i] = '0; pFc[i] = '0; pFo[i] = 1'b0; nBc[i] = '0;
        end
        for (int n = 0; n <= 400; n++) begin
            case ($urandom % 4)
                0: d = $urandom;
                1: d = $urandom & $urandom;
                2: d = $urandom | $urandom;
                default: d = (($urandom % 2) == 0) ? 32'hFFFF_FFFF : 32'h5555_5555;
            endcase
            e = (n < 400) && (($urandom % 5) != 0);
            s = ($urandom % 5) == 0;
            p = ($urandom % 4) == 0;
            nV = e; nFv = 1'b0; nFe = 1'b0;
            if (e) begin
                oneWord = {d};
                for (int i = 0; i < 4; i++) nBc[i] = 6'(countRuns(oneWord, mlOf(i)));
                if (s) begin
                    nFe = inFrame;
                    frameWords = {d};
                    inFrame = 1'b1;
                end else if (inFrame) begin
                    frameWords.push_back(d);
                end
                if (inFrame && p) begin
                    for (int i = 0; i < 4; i++) begin
                        tot = countRuns(frameWords, mlOf(i));
                        mx = (1 << fwOf(i)) - 1;
                        pubFc[i] = 16'((tot > mx) ? mx : tot);
                        pubFo[i] = tot > mx;
                    end
                    nFv = 1'b1;
                    inFrame = 1'b0;
                end
            end
            drive(d, e, s, p);
            for (int i = 0; i < 4; i++) begin
                checks++; if (v[i] !== pV) begin errors++; $display("[TB] FAIL rand_valid inst%0d step%0d: got %0d expected %0d", i, n, v[i], pV); end
                if (pV) begin
                    checks++; if (bc[i] !== pBc[i]) begin errors++; $display("[TB] FAIL rand_block_cnt inst%0d step%0d: got %0d expected %0d", i, n, bc[i], pBc[i]); end
                end
                checks++; if (fv[i] !== pFv) begin errors++; $display("[TB] FAIL rand_frame_valid inst%0d step%0d: got %0d expected %0d", i, n, fv[i], pFv); end
                checks++; if (fc[i] !== pFc[i]) begin errors++; $display("[TB] FAIL rand_frame_cnt inst%0d step%0d: got %0d expected %0d", i, n, fc[i], pFc[i]); end
                checks++; if (fo[i] !== pFo[i]) begin errors++; $display("[TB] FAIL rand_frame_ovf inst%0d step%0d: got %0d expected %0d", i, n, fo[i], pFo[i]); end
                checks++; if (fe[i] !== pFe) begin errors++; $display("[TB] FAIL rand_frame_err inst%0d step%0d: got %0d expected %0d", i, n, fe[i], pFe); end
            end
            pV = nV; pFv = nFv; pFe = nFe;
            for (int i = 0; i < 4; i++) begin
                pBc[i] = nBc[i]; pFc[i] = pubFc[i]; pFo[i] = pubFo[i];
            end
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        data     = '0;
        data_enb = 1'b0;
        sop      = 1'b0;
        eop      = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_min_len2();
        test_cross_boundary();
        test_saturation();
        test_sop_mid_frame();
        test_back_to_back();
        test_idle_hold();
        test_reset_mid_pipeline();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
